// File: rtl/urv_writeback_split.sv
// Write-back stage: load formatting, rd source select, registered RF write port,
// with word-crossing loads either split into two reads or trapped as a fault.
module urv_writeback_split #(
  parameter int unsigned g_with_ecc   = 0,
  parameter int unsigned g_misaligned = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [2:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [1:0]  x_ecc_flip_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_dm_load_o,
  output logic [31:0] w_dm_addr_o,
  output logic        w_stall_req_o,
  output logic        w_misaligned_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic [6:0]  rf_rd_ecc_o,
  output logic [1:0]  rf_rd_ecc_flip_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ECC_W = 7;

  localparam logic [2:0] RD_SOURCE_SHIFTER  = 3'b001;
  localparam logic [2:0] RD_SOURCE_MULTIPLY = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE_HI = 2'd1,
    S_WAIT_HI  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        lo_q;
  logic [XLEN-1:0]        rd_value_q;
  logic [4:0]             rd_q;
  logic                   rd_write_q;
  logic                   misaligned_q;
  logic [ECC_W-1:0]       ecc_q;
  logic [1:0]             ecc_flip_q;

  logic [1:0]             offset;
  logic                   crossing;
  logic [2*XLEN-1:0]      pair;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        load_value;
  logic [XLEN-1:0]        src_value;
  logic [XLEN-1:0]        commit_value;
  logic                   commit;
  logic                   fault;
  logic                   lo_load;
  logic                   stall;

  // Hamming(38,32) check bits plus an overall parity bit over data and check bits.
  function automatic logic [ECC_W-1:0] ecc_calc(input logic [XLEN-1:0] d);
    logic [ECC_W-1:0] e;
    logic [5:0]       p;
    int unsigned      k;
    e = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++) begin
      p = 6'(pos);
      if ((p & (p - 6'd1)) != 6'd0) begin
        for (int j = 0; j < 6; j++) begin
          if (p[j]) e[j] = e[j] ^ d[5'(k)];
        end
        k = k + 1;
      end
    end
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  // Crossing detection and merged-word formatting shared by aligned and split loads.
  always_comb begin
    offset = x_dm_addr_i[1:0];
    case (x_fun_i[1:0])
      2'b00:   crossing = 1'b0;
      2'b01:   crossing = (offset == 2'd3);
      default: crossing = (offset != 2'd0);
    endcase

    pair    = (state_q == S_WAIT_HI) ? {dm_data_l_i, lo_q} : {{XLEN{1'b0}}, dm_data_l_i};
    shifted = XLEN'(pair >> {offset, 3'b000});

    case (x_fun_i[1:0])
      2'b00:   load_value = x_fun_i[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_value = x_fun_i[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_value = shifted;
    endcase

    case (x_rd_source_i)
      RD_SOURCE_SHIFTER:  src_value = x_shifter_rd_value_i;
      RD_SOURCE_MULTIPLY: src_value = x_multiply_rd_value_i;
      default:            src_value = x_rd_value_i;
    endcase
  end

  // Next-state, commit decision and stall request.
  always_comb begin
    state_d      = state_q;
    commit       = 1'b0;
    commit_value = src_value;
    fault        = 1'b0;
    lo_load      = 1'b0;
    stall        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (x_valid_i && x_load_i) begin
          if (!dm_load_done_i) begin
            stall = 1'b1;
          end else if (crossing) begin
            if (g_misaligned != 0) begin
              lo_load = 1'b1;
              stall   = 1'b1;
              state_d = S_ISSUE_HI;
            end else begin
              fault = 1'b1;
            end
          end else begin
            commit       = 1'b1;
            commit_value = load_value;
          end
        end else if (x_valid_i && !x_store_i && x_rd_write_i) begin
          commit = 1'b1;
        end
      end
      S_ISSUE_HI: begin
        stall   = 1'b1;
        state_d = x_valid_i ? S_WAIT_HI : S_IDLE;
      end
      S_WAIT_HI: begin
        stall = !dm_load_done_i;
        if (!x_valid_i) begin
          state_d = S_IDLE;
        end else if (dm_load_done_i) begin
          commit       = 1'b1;
          commit_value = load_value;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (x_valid_i && x_store_i && !dm_store_done_i) stall = 1'b1;
  end

  // State, low-word latch and registered RF write port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      lo_q         <= '0;
      rd_value_q   <= '0;
      rd_q         <= '0;
      rd_write_q   <= 1'b0;
      misaligned_q <= 1'b0;
      ecc_q        <= '0;
      ecc_flip_q   <= '0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= fault;
      rd_write_q   <= commit;
      if (lo_load) lo_q <= dm_data_l_i;
      if (commit) begin
        rd_value_q <= commit_value;
        rd_q       <= x_rd_i;
        ecc_q      <= (g_with_ecc != 0) ? ecc_calc(commit_value) : '0;
        ecc_flip_q <= (g_with_ecc != 0) ? x_ecc_flip_i : 2'b00;
      end
    end
  end

  assign w_dm_load_o      = (state_q == S_ISSUE_HI);
  assign w_dm_addr_o      = {x_dm_addr_i[31:2] + 30'd1, 2'b00};
  assign w_stall_req_o    = stall;
  assign w_misaligned_o   = misaligned_q;
  assign rf_rd_o          = rd_q;
  assign rf_rd_value_o    = rd_value_q;
  assign rf_rd_write_o    = rd_write_q;
  assign rf_rd_ecc_o      = ecc_q;
  assign rf_rd_ecc_flip_o = ecc_flip_q;

endmodule
